// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stalls and flushes
// the pipeline registers for load-use, taken-branch, fetch-miss and data-memory wait.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            state,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              freeze;
    logic              br_flush;

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    // An idle data port (dmem_req = 0) never holds the pipeline.
    assign freeze = dmem_req && !dmem_ready;

    assign state = state_q;

    // RUN and DWAIT share the enable logic: the wait cycle that sees dmem_ready
    // already resolves branch / load-use / fetch, so only the wait counter differs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        br_flush    = 1'b0;
        next_state  = RUN;

        if (!rst) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (freeze) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_we  = 1'b0;
            mem_wb_we  = 1'b0;
            next_state = DWAIT;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
        end else if (lu) begin
            // The bubble clears ex_mem_read, so this lasts exactly one cycle.
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q   <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= next_state;

            if (next_state == RUN) begin
                wait_cnt <= '0;
            end else if (state_q == DWAIT && wait_cnt != TIMEOUT_V) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Sticky: the FSM keeps waiting, only reset clears the flag.
            if (state_q == DWAIT && wait_cnt == TIMEOUT_V) begin
                mem_err <= 1'b1;
            end

            if (!pc_we && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations
// per cycle, an independent monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             ex_mem_read, ex_branch_taken;
    logic             imem_ready, dmem_req, dmem_ready;
    logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic             if_id_flush, id_ex_flush;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    string       name_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] mask_q[$];

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
    localparam logic [6:0] DEF = 7'b11111_00;
    localparam logic [6:0] FRZ = 7'b00000_00;
    localparam logic [6:0] LU  = 7'b00111_01;
    localparam logic [6:0] BR  = 7'b11111_11;
    localparam logic [6:0] IM  = 7'b01111_10;

    localparam logic [17:0] ALL   = 18'h3FFFF;
    localparam logic [17:0] NO_ST = 18'b1111111_00_1_1111_1111;

    hazard_ctrl #(
        .REG_ADDR_W (5),
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .id_ex_we       (id_ex_we),
        .ex_mem_we      (ex_mem_we),
        .mem_wb_we      (mem_wb_we),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .state          (state),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input logic [6:0] wf, input logic [1:0] st,
                                       input logic err, input logic [3:0] sc,
                                       input logic [3:0] fc);
        return {wf, st, err, sc, fc};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got we/fl=%b st=%0d err=%b stall=%0d flush=%0d, expected we/fl=%b st=%0d err=%b stall=%0d flush=%0d",
                     name, act[17:11], act[10:9], act[8], act[7:4], act[3:0],
                     exp[17:11], exp[10:9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string name, input logic [17:0] exp, input logic [17:0] mask);
        name_q.push_back(name);
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic lu_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    always @(negedge clk) begin
        if (name_q.size() > 0) begin
            string       n;
            logic [17:0] e, m, a;
            n = name_q.pop_front();
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            a = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
                 state, mem_err, stall_cnt, flush_cnt};
            check(n, a & m, e & m);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold", pk(FRZ, 2'd0, 1'b0, 4'd0, 4'd0), ALL);
        rst = 1'b1;
        cyc("idle", pk(DEF, 2'd0, 1'b0, 4'd0, 4'd0), ALL);

        // Load-use on rs2, then the bubble clears it
        lu_inputs();
        cyc("lu_rs2", pk(LU, 2'd0, 1'b0, 4'd0, 4'd0), ALL);
        ex_mem_read = 1'b0;
        cyc("lu_after", pk(DEF, 2'd0, 1'b0, 4'd1, 4'd0), ALL);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("lu_rd0", pk(DEF, 2'd0, 1'b0, 4'd1, 4'd0), ALL);
        ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd5;
        cyc("lu_rs1", pk(LU, 2'd0, 1'b0, 4'd1, 4'd0), ALL);
        id_uses_rs1 = 1'b0;
        cyc("lu_unused", pk(DEF, 2'd0, 1'b0, 4'd2, 4'd0), ALL);
        idle_inputs();

        // Branch beats load-use; load-use beats imem miss
        lu_inputs(); ex_branch_taken = 1'b1;
        cyc("br_lu", pk(BR, 2'd0, 1'b0, 4'd2, 4'd0), ALL);
        idle_inputs();
        cyc("br_after", pk(DEF, 2'd0, 1'b0, 4'd2, 4'd1), ALL);
        lu_inputs(); imem_ready = 1'b0;
        cyc("lu_imem", pk(LU, 2'd0, 1'b0, 4'd2, 4'd1), ALL);
        idle_inputs();
        cyc("lu_imem_after", pk(DEF, 2'd0, 1'b0, 4'd3, 4'd1), ALL);

        // Three-cycle data-memory wait
        dmem_req = 1'b1; dmem_ready = 1'b0;
        cyc("dw_1", pk(FRZ, 2'd0, 1'b0, 4'd3, 4'd1), ALL);
        cyc("dw_2", pk(FRZ, 2'd1, 1'b0, 4'd4, 4'd1), ALL);
        cyc("dw_3", pk(FRZ, 2'd1, 1'b0, 4'd5, 4'd1), ALL);
        dmem_ready = 1'b1;
        cyc("dw_ready", pk(DEF, 2'd0, 1'b0, 4'd6, 4'd1), NO_ST);
        idle_inputs();
        cyc("dw_after", pk(DEF, 2'd0, 1'b0, 4'd6, 4'd1), ALL);

        // Branch held through a two-cycle wait
        ex_branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        cyc("bw_1", pk(FRZ, 2'd0, 1'b0, 4'd6, 4'd1), ALL);
        cyc("bw_2", pk(FRZ, 2'd1, 1'b0, 4'd7, 4'd1), ALL);
        dmem_ready = 1'b1;
        cyc("bw_ready", pk(BR, 2'd0, 1'b0, 4'd8, 4'd1), NO_ST);
        idle_inputs();
        cyc("bw_after", pk(DEF, 2'd0, 1'b0, 4'd8, 4'd2), ALL);

        // Fetch not ready for two cycles
        imem_ready = 1'b0;
        cyc("im_1", pk(IM, 2'd0, 1'b0, 4'd8, 4'd2), ALL);
        cyc("im_2", pk(IM, 2'd0, 1'b0, 4'd9, 4'd2), ALL);
        imem_ready = 1'b1;
        cyc("im_after", pk(DEF, 2'd0, 1'b0, 4'd10, 4'd2), ALL);

        // Timeout: ten low-ready cycles; mem_err after DWAIT cycle 5, stall_cnt saturates at 15
        dmem_req = 1'b1; dmem_ready = 1'b0;
        cyc("to_run", pk(FRZ, 2'd0, 1'b0, 4'd10, 4'd2), ALL);
        cyc("to_d1", pk(FRZ, 2'd1, 1'b0, 4'd11, 4'd2), ALL);
        cyc("to_d2", pk(FRZ, 2'd1, 1'b0, 4'd12, 4'd2), ALL);
        cyc("to_d3", pk(FRZ, 2'd1, 1'b0, 4'd13, 4'd2), ALL);
        cyc("to_d4", pk(FRZ, 2'd1, 1'b0, 4'd14, 4'd2), ALL);
        cyc("to_d5", pk(FRZ, 2'd1, 1'b0, 4'd15, 4'd2), ALL);
        cyc("to_d6", pk(FRZ, 2'd1, 1'b1, 4'd15, 4'd2), ALL);
        cyc("to_d7", pk(FRZ, 2'd1, 1'b1, 4'd15, 4'd2), ALL);
        cyc("to_d8", pk(FRZ, 2'd1, 1'b1, 4'd15, 4'd2), ALL);
        cyc("to_d9", pk(FRZ, 2'd1, 1'b1, 4'd15, 4'd2), ALL);

        // Reset mid-wait: enables drop to zero during reset even with no hazard present
        rst = 1'b0; dmem_req = 1'b0;
        cyc("rst_in_wait", pk(FRZ, 2'd1, 1'b1, 4'd15, 4'd2), ALL);
        rst = 1'b1;
        cyc("rst_cleared", pk(DEF, 2'd0, 1'b0, 4'd0, 4'd0), ALL);

        @(negedge clk);
        #1;
        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", name_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It stalls and flushes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four hazards: load-use, taken branch, instruction-memory not ready, and data-memory wait. A small FSM holds the whole pipeline frozen across multi-cycle data-memory accesses, with a timeout error flag and saturating stall/flush performance counters.

## Interface
- `REG_ADDR_W`, default 5: register address width
- `CNT_W`, default 32: performance counter width
- `MEM_TIMEOUT`, default 255: DWAIT cycles before `mem_err` sets
- `clk`, in, 1: clock
- `rst`, in, 1: **reset is synchronous and active-low**
- `id_rs1`, `id_rs2`, in, REG_ADDR_W each: source register fields from IF/ID
- `id_uses_rs1`, `id_uses_rs2`, in, 1 each: the instruction in ID reads rs1 / rs2
- `ex_rd`, in, REG_ADDR_W: ID/EX rd
- `ex_mem_read`, in, 1: ID/EX MemRead
- `ex_branch_taken`, in, 1: branch or jump resolved taken in EX
- `imem_ready`, in, 1: fetch data valid this cycle
- `dmem_req`, in, 1: MEM stage access active
- `dmem_ready`, in, 1: data memory completes the access this cycle
- `pc_we`, `if_id_we`, `id_ex_we`, `ex_mem_we`, `mem_wb_we`, out, 1 each: register load enables
- `if_id_flush`, `id_ex_flush`, out, 1 each: load a bubble (zeros) instead of inputs; flush overrides `we`
- `state`, out, 2: 0 = RUN, 1 = DWAIT
- `mem_err`, out, 1: sticky timeout flag
- `stall_cnt`, `flush_cnt`, out, CNT_W each: performance counters

## Operation
- Enables and flushes are combinational from `state` and the inputs. State, the wait counter, `mem_err` and the performance counters are registered.
- Defaults: every `we` = 1, every flush = 0.
- Load-use hazard `lu` = `ex_mem_read` & (`ex_rd` != 0) & ((`id_uses_rs1` & `id_rs1` == `ex_rd`) | (`id_uses_rs2` & `id_rs2` == `ex_rd`)).
- In RUN, evaluated in priority order:
  1. `dmem_req` & !`dmem_ready`: freeze. All five `we` = 0, flushes = 0. Next state DWAIT.
  2. `ex_branch_taken`: `pc_we` = 1 (redirect mux is external), `if_id_flush` = 1, `id_ex_flush` = 1, other `we` = 1.
  3. `lu`: `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1, downstream `we` = 1. Exactly one bubble results, because the bubble clears `ex_mem_read`.
  4. !`imem_ready`: `pc_we` = 0, `if_id_flush` = 1, the rest default.
  5. Otherwise: defaults.
- In DWAIT:
  - While !`dmem_ready`: freeze as in case 1. `ex_branch_taken` and `lu` are ignored; their inputs stay frozen and are re-evaluated after the wait.
  - When `dmem_ready` = 1: apply RUN cases 2–5 in that same cycle. Next state RUN.
- Wait counter:
  - Counts cycles spent in DWAIT and clears on entry to RUN.
  - When it reaches `MEM_TIMEOUT`, `mem_err` is set to 1.
  - `mem_err` clears only on reset. The FSM stays in DWAIT regardless.
- Performance counters:
  - `stall_cnt` increments in every cycle with `pc_we` = 0.
  - `flush_cnt` increments in every cycle with `id_ex_flush` = 1 caused by case 2 only.
  - Both saturate at 2^CNT_W − 1.
- `dmem_req` = 0 is always treated as ready.

## Timing
- Reset: `rst` = 0 sampled at a `clk` rising edge gives state RUN, wait counter 0, `mem_err` 0, `stall_cnt` 0, `flush_cnt` 0.
- While `rst` = 0: all `we` = 0 and all flushes = 0, so the pipeline holds.
- Reset mid-DWAIT: the FSM returns to RUN on the next edge and the counters clear. The bench must verify this.
- Latency:
  - Hazard response takes 0 cycles, same cycle as the hazard condition.
  - The state change is visible 1 cycle later.
- DWAIT exit is 0-cycle: the `dmem_ready` cycle already carries the RUN enables.
- Simultaneous events:
  - dmem wait beats branch, branch beats load-use, load-use beats imem.
  - Branch and `lu` together produce only the flush; no extra stall cycle.
- `mem_err` rises on the edge where the wait count equals `MEM_TIMEOUT` (DWAIT cycle `MEM_TIMEOUT` + 1).

## Test plan
- **Load-use.** `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_uses_rs2` = 1 for 1 cycle. Expect `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1 for exactly that cycle. Expect `stall_cnt` 0→1. Repeat with `ex_rd` = 0: expect no stall.
- **Taken branch with load-use.** `ex_branch_taken` = 1 together with the load-use inputs above. Expect `pc_we` = 1, `if_id_flush` = 1, `id_ex_flush` = 1. Expect `flush_cnt` to increment and `stall_cnt` to stay unchanged.
- **Data-memory wait.** `dmem_req` = 1 with `dmem_ready` low for 3 cycles, then high. Expect all `we` = 0 for 3 cycles and `state` = 1 for 2 cycles (from the edge after the first). In the ready cycle, expect `we` = 1. Expect `state` = 0 afterwards and `stall_cnt` = 3.
- **Branch during data wait.** `ex_branch_taken` = 1 throughout a 2-cycle dmem wait. Expect no flush during the wait. Expect the flush asserted only in the `dmem_ready` cycle.
- **Timeout, then reset.** `MEM_TIMEOUT` = 4, `dmem_ready` held low for 10 cycles. Expect `mem_err` = 1 after the 5th DWAIT cycle and to stay set. Then drive `rst` = 0 for 1 edge. Expect `state` = 0, `mem_err` = 0, counters = 0.
- **Imem not ready.** `imem_ready` = 0 for 2 cycles. Expect `pc_we` = 0 and `if_id_flush` = 1 for those 2 cycles, with `id_ex_we` = 1.
